// File: rtl/hs_master_fifo.sv
// Write-side FIFO feeding a registered valid/ready output stage with a
// per-packet beat counter that flags the final beat of each BURST-beat packet.
module hs_master_fifo #(
    parameter int L     = 8,
    parameter int DEPTH = 4,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ven,
    input  logic [L-1:0]             data_in,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ready,
    output logic                     valid,
    output logic [L-1:0]             data_out,
    output logic                     last
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_C   = (AW+1)'(0);
    localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);

    logic [L-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          valid_r;
    logic [L-1:0]  data_r;
    logic          last_r;
    logic          ovf_r;
    logic [BW-1:0] beat_r;

    logic          wr_en_s;
    logic          rd_en_s;
    logic          xfer_s;
    logic          full_s;
    logic [AW:0]   count_nxt_s;
    logic          valid_nxt_s;
    logic [BW-1:0] beat_nxt_s;
    logic          last_nxt_s;
    logic          ovf_nxt_s;

    assign full_s   = (count_r == DEPTH_C);
    assign full     = full_s;
    assign level    = count_r;
    assign ovf      = ovf_r;
    assign valid    = valid_r;
    assign data_out = data_r;
    assign last     = last_r;

    // Handshake decode and next-state for occupancy, output stage and beat counter.
    always_comb begin
        wr_en_s     = ven && !full_s;
        rd_en_s     = (count_r != ZERO_C) && (!valid_r || ready);
        xfer_s      = valid_r && ready;
        ovf_nxt_s   = ovf_r || (ven && full_s);
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
        if (rd_en_s) begin
            valid_nxt_s = 1'b1;
        end else if (xfer_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
        if (xfer_s) begin
            if (beat_r == BEAT_MAX) begin
                beat_nxt_s = BW'(0);
            end else begin
                beat_nxt_s = beat_r + BW'(1);
            end
        end else begin
            beat_nxt_s = beat_r;
        end
        // last is registered from the next-state values so it never lags valid.
        last_nxt_s = valid_nxt_s && (beat_nxt_s == BEAT_MAX);
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy, output stage and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            data_r   <= '0;
            last_r   <= 1'b0;
            ovf_r    <= 1'b0;
            beat_r   <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                data_r   <= mem[rd_ptr_r];
            end
            count_r <= count_nxt_s;
            valid_r <= valid_nxt_s;
            last_r  <= last_nxt_s;
            ovf_r   <= ovf_nxt_s;
            beat_r  <= beat_nxt_s;
        end
    end

endmodule

// File: tb/tb_hs_master_fifo.sv
// Directed bench for hs_master_fifo: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_hs_master_fifo;

    localparam int L     = 8;
    localparam int DEPTH = 4;
    localparam int BURST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ven = 1'b0;
    logic [L-1:0] data_in = '0;
    logic         ready = 1'b0;
    logic         full;
    logic [2:0]   level;
    logic         ovf;
    logic         valid;
    logic [L-1:0] data_out;
    logic         last;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [L-1:0] q[$];
    logic         m_valid = 1'b0;
    logic [L-1:0] m_data  = '0;
    int           m_beat  = 0;
    logic         m_ovf   = 1'b0;
    bit           m_wr, m_rd, m_xf;
    int           m_sz;

    hs_master_fifo #(.L(L), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .ven(ven), .data_in(data_in),
        .full(full), .level(level), .ovf(ovf), .ready(ready),
        .valid(valid), .data_out(data_out), .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pop into the output stage, then push the accepted write.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_beat  = 0;
            m_ovf   = 1'b0;
        end else begin
            m_sz = q.size();
            m_xf = m_valid && ready;
            m_rd = (m_sz > 0) && (!m_valid || ready);
            m_wr = ven && (m_sz < DEPTH);
            if (ven && m_sz >= DEPTH) m_ovf = 1'b1;
            if (m_xf) m_beat = (m_beat + 1) % BURST;
            if (m_rd) begin
                m_data  = q.pop_front();
                m_valid = 1'b1;
            end else if (m_xf) begin
                m_valid = 1'b0;
            end
            if (m_wr) q.push_back(data_in);
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        chk("m_valid", 32'(valid), 32'(m_valid));
        chk("m_data", 32'(data_out), 32'(m_data));
        chk("m_last", 32'(last), 32'(m_valid && (m_beat == BURST - 1)));
        chk("m_full", 32'(full), 32'(q.size() == DEPTH));
        chk("m_level", 32'(level), 32'(q.size()));
        chk("m_ovf", 32'(ovf), 32'(m_ovf));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ven   = 1'b0;
        ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        cycle();
        cycle();
        #2 rst = 1'b1;
        cycle();
    endtask

    int beat;
    int first_k;
    int last_k;

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        cycle();
        #2 rst = 1'b1;
        cycle();

        // single word A5 with ready high
        ven = 1'b1; data_in = 8'hA5; ready = 1'b1;
        cycle();
        ven = 1'b0;
        chk("a5_lat_valid", 32'(valid), 32'h0);
        chk("a5_lat_level", 32'(level), 32'h1);
        cycle();
        chk("a5_valid", 32'(valid), 32'h1);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_level", 32'(level), 32'h0);
        cycle();
        chk("a5_drop_valid", 32'(valid), 32'h0);
        chk("a5_end_level", 32'(level), 32'h0);

        // fill with ready low, then overflow
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            ven = 1'b1; data_in = 8'(i);
            cycle();
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_level", 32'(level), 32'h4);
        chk("fill_head", 32'(data_out), 32'h01);
        chk("fill_ovf0", 32'(ovf), 32'h0);
        data_in = 8'h06;
        cycle();
        ven = 1'b0;
        chk("ovf_set", 32'(ovf), 32'h1);
        chk("ovf_level", 32'(level), 32'h4);
        ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("drain_valid", 32'(valid), 32'h1);
            chk("drain_data", 32'(data_out), 32'(i));
            cycle();
        end
        chk("drain_empty", 32'(valid), 32'h0);
        chk("ovf_sticky", 32'(ovf), 32'h1);

        // backpressure on 0x33
        do_reset();
        chk("bp_ovf_clr", 32'(ovf), 32'h0);
        ven = 1'b1; data_in = 8'h33;
        cycle();
        ven = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(valid), 32'h1);
            chk("bp_data", 32'(data_out), 32'h33);
            chk("bp_last", 32'(last), 32'h0);
            cycle();
        end
        ready = 1'b1;
        cycle();
        chk("bp_done", 32'(valid), 32'h0);

        // streaming 8 words across pointer wrap
        do_reset();
        ready = 1'b1;
        beat = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 12; k++) begin
            ven = (k < 8); data_in = 8'(8'h10 + k);
            cycle();
            if (valid) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                chk("st_data", 32'(data_out), 32'(8'h10 + beat));
                chk("st_last", 32'(last), 32'((beat == 3) || (beat == 7)));
                beat++;
            end
        end
        ven = 1'b0;
        chk("st_beats", 32'(beat), 32'd8);
        chk("st_first", 32'(first_k), 32'd1);
        chk("st_span", 32'(last_k - first_k), 32'd7);

        // reset while full and valid
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ven = 1'b1; data_in = 8'(8'h40 + i);
            cycle();
        end
        ven = 1'b0;
        chk("pre_full", 32'(full), 32'h1);
        chk("pre_valid", 32'(valid), 32'h1);
        chk("pre_ovf", 32'(ovf), 32'h1);
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(valid), 32'h0);
        chk("ar_data", 32'(data_out), 32'h0);
        chk("ar_last", 32'(last), 32'h0);
        chk("ar_full", 32'(full), 32'h0);
        chk("ar_level", 32'(level), 32'h0);
        chk("ar_ovf", 32'(ovf), 32'h0);
        #2 rst = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_valid", 32'(valid), 32'h0);
            chk("post_ovf", 32'(ovf), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
